// File: rtl/bcd_modulo_counter.sv
// Two-digit BCD up/down counter with a parametrised modulus, parallel load,
// synchronous clear and a zero-latency carry/borrow for cascading stages.
module bcd_modulo_counter #(
    parameter int MODULO    = 60,
    parameter int RESET_VAL = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       up_dn,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_high,
    input  logic [3:0] load_low,
    output logic [3:0] lowDigit,
    output logic [3:0] highDigit,
    output logic       cout,
    output logic       load_err
);

    localparam logic [6:0] MOD_VAL   = 7'(MODULO);
    localparam logic [6:0] TERM_VAL  = 7'(MODULO - 1);
    localparam logic [3:0] TERM_HIGH = 4'((MODULO - 1) / 10);
    localparam logic [3:0] TERM_LOW  = 4'((MODULO - 1) % 10);
    localparam logic [3:0] RST_HIGH  = 4'(RESET_VAL / 10);
    localparam logic [3:0] RST_LOW   = 4'(RESET_VAL % 10);

    logic [3:0] low_reg, low_next;
    logic [3:0] high_reg, high_next;
    logic       err_reg, err_next;

    logic [6:0] value;
    logic [6:0] load_value;
    logic       load_ok;
    logic       at_top;
    logic       at_zero;

    assign value      = {3'b000, high_reg} * 7'd10 + {3'b000, low_reg};
    // Only meaningful once both load digits are known to be BCD (max 99).
    assign load_value = {3'b000, load_high} * 7'd10 + {3'b000, load_low};
    assign load_ok    = (load_high <= 4'd9) && (load_low <= 4'd9) && (load_value < MOD_VAL);
    assign at_top     = (value == TERM_VAL);
    assign at_zero    = (value == 7'd0);

    always_comb begin
        low_next  = low_reg;
        high_next = high_reg;
        err_next  = 1'b0;
        if (load) begin
            if (load_ok) begin
                low_next  = load_low;
                high_next = load_high;
            end else begin
                err_next = 1'b1;
            end
        end else if (clr) begin
            low_next  = RST_LOW;
            high_next = RST_HIGH;
        end else if (en) begin
            if (up_dn) begin
                if (at_top) begin
                    low_next  = 4'd0;
                    high_next = 4'd0;
                end else if (low_reg == 4'd9) begin
                    low_next  = 4'd0;
                    high_next = high_reg + 4'd1;
                end else begin
                    low_next = low_reg + 4'd1;
                end
            end else begin
                if (at_zero) begin
                    low_next  = TERM_LOW;
                    high_next = TERM_HIGH;
                end else if (low_reg == 4'd0) begin
                    low_next  = 4'd9;
                    high_next = high_reg - 4'd1;
                end else begin
                    low_next = low_reg - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            low_reg  <= RST_LOW;
            high_reg <= RST_HIGH;
            err_reg  <= 1'b0;
        end else begin
            low_reg  <= low_next;
            high_reg <= high_next;
            err_reg  <= err_next;
        end
    end

    // Gated by reset so a downstream stage cannot step while this one is held.
    assign cout = reset & en & ~load & ~clr &
                  ((up_dn & at_top) | (~up_dn & at_zero));

    assign lowDigit  = low_reg;
    assign highDigit = high_reg;
    assign load_err  = err_reg;

endmodule
